// File: rtl/riscv_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one-cycle special cases.
// Optional macro RISCV_MDU_FAST_MUL_EN: single-cycle multiplies through a registered full product.
module riscv_mdu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | DATA_W shift-add / shift-subtract iterations
  // FIX   | sign correction and result selection
  // DONE  | result valid, done pulse
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CNT_W = $clog2(DATA_W);
`ifdef RISCV_MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opnd;
  logic [2:0]          f3;
  logic                neg_q, neg_r;

  logic              is_div, a_signed, b_signed, a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic              div_zero, div_ovf, special, launch;
  logic [DATA_W-1:0] special_res, fast_res, fix_res;

  assign is_div   = funct3[2];
  assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = is_div ? ~funct3[0] : ~funct3[1];
  assign a_neg    = a_signed & op_a[DATA_W-1];
  assign b_neg    = b_signed & op_b[DATA_W-1];
  assign a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
  assign b_mag    = b_neg ? (~op_b + 1'b1) : op_b;

  assign div_zero = is_div && (op_b == '0);
  assign div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(DATA_W-1){1'b0}}}) && (op_b == '1);
  assign special  = div_zero || div_ovf;
  // funct3[1] separates REM/REMU from DIV/DIVU
  assign special_res = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
  assign launch   = (state == IDLE) && start && !flush;

`ifdef RISCV_MDU_FAST_MUL_EN
  logic signed [2*DATA_W-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{DATA_W{a_neg}}, op_a};
  assign fast_b    = {{DATA_W{b_neg}}, op_b};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[DATA_W-1:0] : fast_prod[2*DATA_W-1:DATA_W];
`else
  assign fast_res  = '0;
`endif

  // Multiply step: add multiplicand into the high half when the multiplier LSB is set, then shift right.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_step;
  assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, acc[DATA_W-1:1]};

  // Divide step: partial remainder in the high half, quotient shifts in from the bottom.
  logic [DATA_W:0]     div_shift, div_diff;
  logic [2*DATA_W-1:0] div_step;
  assign div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_step  = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                      : {div_diff[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};

  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quot_fix, rem_fix;
  assign prod_fix = neg_q ? (~acc + 1'b1) : acc;
  assign quot_fix = neg_q ? (~acc[DATA_W-1:0] + 1'b1) : acc[DATA_W-1:0];
  assign rem_fix  = neg_r ? (~acc[2*DATA_W-1:DATA_W] + 1'b1) : acc[2*DATA_W-1:DATA_W];

  always_comb begin
    fix_res = '0;
    case (f3)
      3'b000:                 fix_res = prod_fix[DATA_W-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*DATA_W-1:DATA_W];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (launch) state_nx = (special || (FAST_MUL && !is_div)) ? DONE : CALC;
      CALC: if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      f3     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (launch) begin
          f3    <= funct3;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= CNT_W'(DATA_W-1);
          if (is_div) begin
            acc  <= {{DATA_W{1'b0}}, a_mag};
            opnd <= b_mag;
          end else begin
            acc  <= {{DATA_W{1'b0}}, b_mag};
            opnd <= a_mag;
          end
          if (special)                  result <= special_res;
          else if (FAST_MUL && !is_div) result <= fast_res;
        end
        CALC: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          acc <= f3[2] ? div_step : mul_step;
        end
        FIX: if (!flush) result <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_riscv_mdu.sv
// Directed bench for riscv_mdu: vector table of RV32M ops plus start-ignore, flush and reset sequences.
module tb_riscv_mdu;
  localparam int W = 32;
`ifdef RISCV_MDU_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 34;
`endif

  logic clk = 1'b0;
  logic reset, start, flush, busy, done;
  logic [2:0]   funct3;
  logic [W-1:0] op_a, op_b, result;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  riscv_mdu #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  typedef struct {
    string      name;
    logic [2:0] f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Caller is 1 time unit after an edge; start is driven in this cycle (cycle 0).
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int dc;
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = ~a; op_b = ~b; funct3 = ~f;
    dc = 0;
    for (int c = 1; c <= 60 && dc == 0; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      check({nm, " busy"}, busy, 1'b1);
      if (done) begin
        dc = c;
        check({nm, " result"}, result, exp);
      end
    end
    check({nm, " done cycle"}, dc, lat);
    @(posedge clk); #1;
    check({nm, " idle busy"}, busy, 1'b0);
    check({nm, " idle done"}, done, 1'b0);
  endtask

  initial begin
    int ndone, dc;
    vecs[0]  = '{"mul",          3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ML};
    vecs[1]  = '{"mulh_min",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML};
    vecs[2]  = '{"mulhu_max",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML};
    vecs[3]  = '{"mulhsu",       3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML};
    vecs[4]  = '{"div_neg",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vecs[5]  = '{"rem_neg",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[6]  = '{"divu",         3'b101, 32'd100,       32'd7,         32'd14,        34};
    vecs[7]  = '{"remu",         3'b111, 32'd100,       32'd7,         32'd2,         34};
    vecs[8]  = '{"div_by0",      3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{"remu_by0",     3'b111, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{"div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{"rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{"div_negdiv",   3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    vecs[13] = '{"rem_negdiv",   3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34};
    vecs[14] = '{"divu_max",     3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34};
    vecs[15] = '{"mulhu_2p32",   3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, ML};
    vecs[16] = '{"mul_m1sq",     3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, ML};
    vecs[17] = '{"mulh_m1x1",    3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, ML};

    reset = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    #12;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle after reset", busy, 1'b0);

    // back-to-back: each op starts in the cycle right after the previous done
    for (int i = 0; i < 18; i++)
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // start pulses during a running DIV are ignored
    funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    ndone = 0; dc = 0;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (done) begin
        ndone++;
        dc = c;
        check("busy_start result", result, 32'd14);
      end
      start = (c == 3 || c == 20);
      funct3 = 3'b101; op_a = 32'd1; op_b = 32'd1;
    end
    start = 1'b0;
    check("busy_start done count", ndone, 1);
    check("busy_start done cycle", dc, 34);

    // flush in cycle 10 of a DIV
    funct3 = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2; start = 1'b1;
    ndone = 0;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (done) ndone++;
      if (c == 11) check("flush busy", busy, 1'b0);
      flush = (c == 10);
    end
    flush = 1'b0;
    check("flush done count", ndone, 0);
    check("flush result held", result, 32'd14);

    // asynchronous reset in cycle 5 of a DIVU
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre-reset busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async reset busy", busy, 1'b0);
    check("async reset done", done, 1'b0);
    check("async reset result", result, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post-reset idle", busy, 1'b0);
    run_op("mulhu_after_reset", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_mdu.md
# riscv_mdu

Iterative multiply/divide unit implementing the RV32M `funct3` operation set for a `DATA_W`-wide datapath. It sits beside the ALU in the Datapath and is launched by a one-cycle `start`. It reports `busy` while working and `done` for one cycle when `result` is valid. The Datapath stalls the PC while `busy` is high.

## Interface
- `DATA_W`, default 32: operand/result width; must be even and ≥ 8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; clears all state.
- `start`  in  1  launch request; sampled only when `busy` = 0.
- `flush`  in  1  synchronous abort (pipeline redirect / halt).
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  DATA_W  rs1 value (multiplicand / dividend).
- `op_b`  in  DATA_W  rs2 value (multiplier / divisor).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  DATA_W  last completed result; held until the next completion.

## Operation
- **IDLE.** `start` = 1 with `flush` = 0 latches `funct3`, `op_a` and `op_b`; later input changes are ignored. The next state is:
  - DONE for special cases, and for multiplies when `RISCV_MDU_FAST_MUL_EN` is defined;
  - CALC otherwise.
- **CALC.** Runs `DATA_W` iterations with a counter counting `DATA_W`−1 down to 0.
  - Multiply: unsigned shift-add on operand magnitudes into a 2·`DATA_W` accumulator.
  - Divide: restoring shift-subtract on magnitudes, producing quotient and remainder.
  - Next state: FIX when the counter reaches 0.
- **FIX.** One cycle of sign correction and selection.
  - Signedness: MUL/MULH treat both operands as signed. MULHSU treats `op_a` as signed and `op_b` as unsigned. MULHU, DIVU and REMU are unsigned. DIV and REM are signed.
  - Product: negated if the operand signs differ (signed operands only). MUL returns the low `DATA_W` bits; the MULH* ops return the high `DATA_W` bits.
  - Quotient: negated if the signs differ. Remainder: takes the sign of the dividend.
  - Next state: DONE.
- **DONE.** `result` is registered on entry; `done` = 1 for exactly this cycle. Next state: IDLE. `start` is ignored in DONE.
- **Special cases**, decided in IDLE and completing in 1 cycle:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → `op_a`.
  - Signed overflow (`op_a` = most-negative value, `op_b` = −1): DIV → `op_a`; REM → 0.
- **`flush`.** In any state, moves to IDLE at the next edge. No `done` is produced and `result` is unchanged. If `flush` and `start` are high together in IDLE, `flush` wins and `start` is dropped.
- **`start` while `busy`.** Ignored; no queueing.

## Timing
- Reset values: `busy` = 0, `done` = 0, `result` = 0, state IDLE, counter 0.
- A `reset` assertion mid-operation clears everything immediately (asynchronous). After release, the unit waits in IDLE.
- The `start` cycle is cycle 0.
- Iterative ops: `busy` is high in cycles 1 to `DATA_W`+2; `done` is high in cycle `DATA_W`+2 (cycle 34 at `DATA_W` = 32).
- Special cases and fast multiply: `busy` and `done` are high in cycle 1.
- Back-to-back: the earliest next accepted `start` is in the cycle after `done`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `RISCV_MDU_FAST_MUL_EN` defined:
  - All four multiply ops use a single registered `DATA_W`×`DATA_W` signed/unsigned product and complete in cycle 1 via DONE.
  - Divides remain iterative.
- Undefined:
  - Multiplies use the CALC/FIX path with `DATA_W`+2 latency.
  - No hardware multiplier is inferred.

## Test plan
- **MUL.** MUL 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB. `done` is in cycle 34 without the macro, cycle 1 with it. `busy` is high exactly through the `done` cycle.
- **High-half multiplies.**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Divides.**
  - DIV −7 / 2 → 0xFFFFFFFD; REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU 100 % 7 → 2.
  - Each has `done` in cycle 34.
- **Corner cases.** Each has `done` in cycle 1.
  - DIV 5 / 0 → 0xFFFFFFFF; REMU 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- **Control.**
  - `start` pulses in cycles 3 and 20 of a running DIV are ignored, and exactly one `done` is produced.
  - `flush` in cycle 10 of a DIV: `busy` is 0 in cycle 11, no `done` occurs, and `result` keeps its prior value.
- **Reset.** `reset` driven low in cycle 5 of a DIVU → `busy`, `done` and `result` are 0 before the next edge. After release, a new MULHU completes normally.
